// File: rtl/lockin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lockin_pkg
// Description : Shared widths, FSM state type and the output saturation
//               helper for the lock-in demodulator.
// Revision    : 1.0 - initial release
// ============================================================================
package lockin_pkg;

  localparam int DATA_W   = 16;
  localparam int MAX_LOG2 = 12;
  localparam int PROD_W   = 2 * DATA_W;
  localparam int ACC_W    = PROD_W + MAX_LOG2;
  // One extra bit so the window-end compare value never wraps.
  localparam int CNT_W    = MAX_LOG2 + 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    DUMP = 1'b1
  } state_e;

  // Clamp a wide signed value into the signed DATA_W output range.
  function automatic logic [DATA_W-1:0] sat_to_data(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = ACC_W'((1 << (DATA_W - 1)) - 1);
    lo = -hi - ACC_W'(1);
    if (v > hi) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < lo) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction

  // Window exponents above the supported maximum fall back to the maximum.
  function automatic logic [3:0] clamp_log2(input logic [3:0] d);
    return (d > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lockin_mac_channel.sv
`default_nettype none
// ============================================================================
// Module      : lockin_mac_channel
// Description : One demodulation channel: input register, signed multiply,
//               integrate-and-dump accumulator, mean shift and saturation.
//               Window control (valids, dump, clear, length) comes from top.
// Revision    : 1.0 - initial release
// ============================================================================
module lockin_mac_channel
  import lockin_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] adc_i,
  input  logic [DATA_W-1:0] ref_i,
  input  logic              a_valid_i,
  input  logic              b_valid_i,
  input  logic              clr_i,
  input  logic              dump_i,
  input  logic [3:0]        win_log2_i,
  output logic [DATA_W-1:0] res_o
);

  logic signed [DATA_W-1:0] adc_q;
  logic signed [DATA_W-1:0] ref_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        res_q;

  logic signed [PROD_W-1:0] prod_w;
  logic signed [ACC_W-1:0]  sum_w;
  logic signed [ACC_W-1:0]  mean_w;
  logic signed [ACC_W-1:0]  scaled_w;

  // Operands are sign-extended first so the full product is kept.
  assign prod_w   = PROD_W'(adc_q) * PROD_W'(ref_q);
  assign sum_w    = acc_q + ACC_W'(prod_q);
  assign mean_w   = sum_w >>> win_log2_i;
  assign scaled_w = mean_w >>> (DATA_W - 1);

  // Stage A: capture the sample pair when the input is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q <= '0;
      ref_q <= '0;
    end else if (in_valid_i) begin
      adc_q <= adc_i;
      ref_q <= ref_i;
    end
  end

  // Stage B: register the signed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (a_valid_i) begin
      prod_q <= prod_w;
    end
  end

  // Stage C: integrate, or empty the accumulator on the window's last sample.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (b_valid_i) begin
      acc_q <= dump_i ? '0 : sum_w;
    end
  end

  // Result register: updated only on a dump, holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else if (dump_i) begin
      res_q <= sat_to_data(scaled_w);
    end
  end

  assign res_o = res_q;

endmodule
`default_nettype wire

// File: rtl/lockin_demod.sv
`default_nettype none
// ============================================================================
// Module      : lockin_demod
// Description : Dual-channel lock-in demodulator. Shared valid pipeline,
//               sample counter and FILL/DUMP control drive the I (sin) and
//               Q (cos) channels so both dump on the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lockin_demod
  import lockin_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] adc_in,
  input  logic [DATA_W-1:0] sin_in,
  input  logic [DATA_W-1:0] cos_in,
  input  logic [3:0]        dec_log2,
  input  logic              sync_in,
  output logic [DATA_W-1:0] i_out,
  output logic [DATA_W-1:0] q_out,
  output logic              out_valid
);

  state_e           state_q;
  state_e           state_d;
  logic             a_valid_q;
  logic             b_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       win_q;
  logic             latch_pend_q;

  logic [3:0]       win_eff_w;
  logic             cnt_last_w;
  logic             dump_w;

  // A pending latch marks a window start (after reset, sync or dump); the
  // window length is taken live from dec_log2 then and frozen afterwards.
  assign win_eff_w  = latch_pend_q ? clamp_log2(dec_log2) : win_q;
  assign cnt_last_w = (cnt_q == ((CNT_W'(1) << win_eff_w) - CNT_W'(1)));
  assign dump_w     = b_valid_q && !sync_in && cnt_last_w;

  // Valid pipeline alongside stages A and B; sync drops in-flight samples.
  always_ff @(posedge clk) begin
    if (rst || sync_in) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      a_valid_q <= in_valid;
      b_valid_q <= a_valid_q;
    end
  end

  // Sample counter within the current window.
  always_ff @(posedge clk) begin
    if (rst || sync_in) begin
      cnt_q <= '0;
    end else if (b_valid_q) begin
      cnt_q <= dump_w ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Window length latch and its pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      latch_pend_q <= 1'b1;
    end else begin
      win_q        <= win_eff_w;
      latch_pend_q <= sync_in || dump_w;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DUMP lasts exactly the cycle after each dump edge.
  always_comb begin
    state_d = FILL;
    if (dump_w) begin
      state_d = DUMP;
    end
  end

  // FSM output: the result strobe.
  always_comb begin
    out_valid = 1'b0;
    if (state_q == DUMP) begin
      out_valid = 1'b1;
    end
  end

  lockin_mac_channel u_chan_i (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .adc_i      (adc_in),
    .ref_i      (sin_in),
    .a_valid_i  (a_valid_q),
    .b_valid_i  (b_valid_q),
    .clr_i      (sync_in),
    .dump_i     (dump_w),
    .win_log2_i (win_eff_w),
    .res_o      (i_out)
  );

  lockin_mac_channel u_chan_q (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .adc_i      (adc_in),
    .ref_i      (cos_in),
    .a_valid_i  (a_valid_q),
    .b_valid_i  (b_valid_q),
    .clr_i      (sync_in),
    .dump_i     (dump_w),
    .win_log2_i (win_eff_w),
    .res_o      (q_out)
  );

endmodule
`default_nettype wire

// File: doc/lockin_demod.md
Name: lockin_demod

Overview:
- Dual-channel lock-in demodulator directly downstream of the DDS compiler.
- Multiplies each ADC sample by the DDS sin/cos reference, accumulates over a 2^dec_log2 sample window (integrate-and-dump), and emits averaged I (sin) and Q (cos) results with a valid strobe.
- Output feeds the PID/lock logic and register readback.

Parameters:
- DATA_W, 16, signed width of adc_in, sin_in, cos_in, i_out, q_out.
- MAX_LOG2, 12, largest supported decimation exponent; accumulator width = 2*DATA_W + MAX_LOG2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  adc_in/sin_in/cos_in valid this cycle.
- adc_in  in  DATA_W  signed ADC sample.
- sin_in  in  DATA_W  signed DDS sine reference.
- cos_in  in  DATA_W  signed DDS cosine reference.
- dec_log2  in  4  window length exponent; window = 2^dec_log2 samples.
- sync_in  in  1  restart window; partial sums discarded.
- i_out  out  DATA_W  signed averaged adc*sin, Q1.15 scaling.
- q_out  out  DATA_W  signed averaged adc*cos, Q1.15 scaling.
- out_valid  out  1  one-cycle strobe, new i_out/q_out.

Behaviour:
- Reset:
  - i_out = 0, q_out = 0, out_valid = 0.
  - Accumulators, sample counter and pipeline valids cleared.
  - Window length re-latched from dec_log2 on the first cycle after reset.
- Pipeline, per channel:
  - Stage A: register inputs when in_valid.
  - Stage B: register signed product, 2*DATA_W bits.
  - Stage C: accumulate, or dump.
  - Valid travels with the data. Gaps in in_valid are allowed and insert no samples.
- Latency:
  - Final window sample accepted on edge n; out_valid is high for exactly the cycle after edge n+2.
  - out_valid is never high on two consecutive cycles unless dec_log2 = 0 and in_valid is continuous.
- Window length:
  - dec_log2 is latched into win_log2 at every window start.
  - Values > MAX_LOG2 clamp to MAX_LOG2.
  - Changes mid-window have no effect until the next window.
- FSM, states FILL and DUMP:
  - FILL: the sample counter increments on each stage-C valid. When counter = 2^win_log2 - 1 and a valid arrives, go to DUMP on the same edge.
  - At that edge: sum = acc + product; mean = sum >>> win_log2 (arithmetic); out = mean[2*DATA_W-2 : DATA_W-1], i.e. mean >>> 15 for DATA_W = 16.
  - DUMP lasts one cycle: out_valid = 1, acc and counter load 0, win_log2 re-latched, return to FILL.
  - A valid sample arriving during DUMP is the first sample of the new window (acc loads product, counter = 1). No sample is lost.
- Saturation: mean >>> 15 spans [-32768, +32768]. +32768, from (-32768)*(-32768), saturates to +32767. All other values pass unchanged.
- Output hold: i_out/q_out hold their value between dumps.
- dec_log2 = 0: every valid sample dumps; output = product >>> 15, saturated.
- sync_in:
  - Clears acc, counter and the stage A/B valids.
  - Re-latches win_log2.
  - Suppresses any dump that would occur the same cycle. sync wins over a simultaneous final sample, and that window produces no output.
  - i_out/q_out keep their last value.
- Reset mid-window: all partial state is discarded; no out_valid is generated for the partial window.
- Overflow: the accumulator width guarantees no wrap for any window up to 2^MAX_LOG2.

Decomposition:
- Package lockin_pkg:
  - DATA_W, MAX_LOG2, PROD_W = 2*DATA_W, ACC_W = PROD_W + MAX_LOG2.
  - FSM state enum {FILL, DUMP}.
  - A saturate-to-DATA_W function.
- Sub-module lockin_mac_channel (one instance each for I and Q):
  - Contains the multiply, accumulate, shift and saturate datapath.
  - Takes shared window control from the top.
- The counter/FSM lives once in lockin_demod so I and Q dump on the same cycle.

Test Plan:
- Constant input, adc=16384, sin=16384, cos=0, dec_log2=2, continuous in_valid -> out_valid every 4th cycle after fill; i_out=8192, q_out=0; first strobe 3 cycles after the 4th sample edge.
- Saturation, adc=-32768, sin=-32768, cos=32767, dec_log2=0 -> every sample: i_out=32767 (saturated), q_out=-32767.
- Sign/averaging, dec_log2=1, samples (adc,sin) = (100,32767) then (-300,32767) -> i_out = ((100-300)*32767/2)>>>15 = -100.
- in_valid toggling 1-0-1-0, dec_log2=3 -> strobe only after 8 valid samples; result equals the gap-free run.
- sync_in asserted after 5 of 8 samples, then 8 samples of adc=1000, sin=32767 -> no strobe for the aborted window; next i_out=999; sync coincident with the 8th sample -> no strobe.
- dec_log2 changed 2 -> 4 mid-window, plus rst mid-window -> current window stays 4 samples and the next is 16; after rst, outputs 0 with no spurious out_valid.
